// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 800x600@60 Hz VGA timing generator.
// Produces 1-based column/row counters (c1/c2) for the pixel-control stage,
// a frame_start pulse, and hsync/vsync/de delayed by SYNC_DLY clocks so they
// line up with the control stage's registered rgb.
module vga_sync_gen #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 4,
  parameter int V_BACK   = 23,
  parameter int V_ACTIVE = 600,
  parameter int V_FRONT  = 1,
  parameter int SYNC_DLY = 4      // legal range 1..8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] c1,
  output logic [10:0] c2,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic        de
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  // Counter-width copies of the timing boundaries.
  localparam logic [10:0] H_TOT_C  = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT_C  = 11'(V_TOTAL);
  localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_C = 11'(V_SYNC);
  localparam logic [10:0] H_DE_LO  = 11'(H_SYNC + H_BACK);             // exclusive
  localparam logic [10:0] H_DE_HI  = 11'(H_SYNC + H_BACK + H_ACTIVE);  // inclusive
  localparam logic [10:0] V_DE_LO  = 11'(V_SYNC + V_BACK);             // exclusive
  localparam logic [10:0] V_DE_HI  = 11'(V_SYNC + V_BACK + V_ACTIVE);  // inclusive

  // One bundle per delay-line stage keeps the three sync terms in lockstep.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  logic [10:0] c1_next;
  logic [10:0] c2_next;
  sync_t       raw;
  sync_t       pipe [SYNC_DLY];

  // Next counter position: leave reset at (1,1), wrap line and frame.
  always_comb begin
    // NOTE: defaults are assigned first so every path drives both signals and
    // no latch is inferred.
    c1_next = c1 + 11'd1;
    c2_next = c2;
    if (c1 == 11'd0) begin
      c1_next = 11'd1;
      c2_next = 11'd1;
    end else if (c1 == H_TOT_C) begin
      c1_next = 11'd1;
      c2_next = (c2 == V_TOT_C) ? 11'd1 : c2 + 11'd1;
    end
  end

  // Undelayed sync/enable terms decoded from the current counter position;
  // the zero (reset) position decodes to the idle values.
  always_comb begin
    raw    = SYNC_IDLE;
    raw.hs = !((c1 != 11'd0) && (c1 <= H_SYNC_C));
    raw.vs = !((c2 != 11'd0) && (c2 <= V_SYNC_C));
    raw.de = (c1 > H_DE_LO) && (c1 <= H_DE_HI) &&
             (c2 > V_DE_LO) && (c2 <= V_DE_HI);
  end

  // Counter and frame_start registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1          <= 11'd0;
      c2          <= 11'd0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      c1          <= c1_next;
      c2          <= c2_next;
      frame_start <= (c1_next == 11'd1) && (c2_next == 11'd1);
    end
  end

  // SYNC_DLY-deep delay line aligning sync/de with the control stage's rgb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: unlike a data memory, every stage is reset here: the outputs
      // must show inactive sync/de until the line refills after reset.
      for (int i = 0; i < SYNC_DLY; i++) pipe[i] <= SYNC_IDLE;
    end else begin
      pipe[0] <= raw;
      for (int i = 1; i < SYNC_DLY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign hsync = pipe[SYNC_DLY-1].hs;
  assign vsync = pipe[SYNC_DLY-1].vs;
  assign de    = pipe[SYNC_DLY-1].de;

endmodule
